// File: rtl/cnn_uart_pkg.sv
// rtl/cnn_uart_pkg.sv - shared constants and state type for the CNN result UART
package cnn_uart_pkg;
  localparam int DEFAULT_BAUD_DIV = 434;
  localparam int FRAME_BITS       = 10;
  localparam int DATA_W           = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } tx_state_t;
endpackage

// File: rtl/cnn_uart_tx_if.sv
// rtl/cnn_uart_tx_if.sv - trmt/tx_data request and TX/bsy/tx_done status between CNN core and UART
interface cnn_uart_tx_if;
  import cnn_uart_pkg::*;

  logic              trmt;
  logic [DATA_W-1:0] tx_data;
  logic              TX;
  logic              bsy;
  logic              tx_done;

  modport master (output trmt, output tx_data, input TX, input bsy, input tx_done);
  modport slave  (input trmt, input tx_data, output TX, output bsy, output tx_done);
endinterface

// File: rtl/cnn_uart_tx.sv
// rtl/cnn_uart_tx.sv - 8N1 UART transmitter returning the CNN classification byte
module cnn_uart_tx
  import cnn_uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic          clk,
  input  logic          rst,
  cnn_uart_tx_if.slave  io
);

  localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

  tx_state_t               state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]           baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic                    tx_q, tx_d;
  logic                    bsy_q, bsy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    bsy_d   = bsy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (io.trmt) begin
          shift_d = {1'b1, io.tx_data, 1'b0};
          baud_d  = '0;
          bit_d   = '0;
          done_d  = 1'b0;
          bsy_d   = 1'b1;
          tx_d    = 1'b0;
          state_d = XMIT;
        end
      end
      XMIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[1];
          // End of stop bit: completion wins over any trmt seen this cycle
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            bsy_d   = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      bsy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      bsy_q   <= bsy_d;
      done_q  <= done_d;
    end
  end

  assign io.TX      = tx_q;
  assign io.bsy     = bsy_q;
  assign io.tx_done = done_q;

endmodule

// File: tb/tb_cnn_uart_tx.sv
// tb/tb_cnn_uart_tx.sv - randomized bench for cnn_uart_tx against a frame-timing reference model
module tb_cnn_uart_tx;

  logic clk;
  logic rst;
  logic clk_en;

  cnn_uart_tx_if if4 ();
  cnn_uart_tx_if if434 ();

  cnn_uart_tx #(.BAUD_DIV(4))   u_dut4   (.clk(clk), .rst(rst), .io(if4));
  cnn_uart_tx #(.BAUD_DIV(434)) u_dut434 (.clk(clk), .rst(rst), .io(if434));

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  // Reference model: a frame is a start time and a byte; outputs follow from elapsed cycles
  bit         sel4;
  int         bdiv;
  int         cyc;
  bit         started;
  int         start_e;
  logic [7:0] fdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    int   el;
    int   idx;
    logic e_tx, e_bsy, e_done;
    logic g_tx, g_bsy, g_done;
    el = cyc - start_e;
    if (started && el < 10 * bdiv) begin
      idx    = el / bdiv;
      e_tx   = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : fdata[idx-1];
      e_bsy  = 1'b1;
      e_done = 1'b0;
    end else begin
      e_tx   = 1'b1;
      e_bsy  = 1'b0;
      e_done = started;
    end
    g_tx   = sel4 ? if4.TX      : if434.TX;
    g_bsy  = sel4 ? if4.bsy     : if434.bsy;
    g_done = sel4 ? if4.tx_done : if434.tx_done;
    chk("tx", 32'(g_tx), 32'(e_tx));
    chk("bsy", 32'(g_bsy), 32'(e_bsy));
    chk("tx_done", 32'(g_done), 32'(e_done));
  endtask

  task automatic tick(input logic t, input logic [7:0] d);
    if (sel4) begin
      if4.trmt      = t;
      if4.tx_data   = d;
      if434.trmt    = 1'b0;
    end else begin
      if434.trmt    = t;
      if434.tx_data = d;
      if4.trmt      = 1'b0;
    end
    @(posedge clk);
    cyc++;
    if (rst)
      started = 0;
    else if (t && (!started || (cyc - start_e) > 10 * bdiv)) begin
      started = 1;
      start_e = cyc;
      fdata   = d;
    end
    #1 check_outputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    sel4     = 1'b1;
    bdiv     = 4;
    cyc      = 0;
    started  = 0;
    start_e  = 0;
    fdata    = '0;
    if4.trmt = 1'b0;   if4.tx_data = '0;
    if434.trmt = 1'b0; if434.tx_data = '0;

    // Reset values with no clock edge at all
    #3;
    chk("rst_tx4", 32'(if4.TX), 32'd1);
    chk("rst_bsy4", 32'(if4.bsy), 32'd0);
    chk("rst_done4", 32'(if4.tx_done), 32'd0);
    chk("rst_tx434", 32'(if434.TX), 32'd1);
    chk("rst_bsy434", 32'(if434.bsy), 32'd0);
    chk("rst_done434", 32'(if434.tx_done), 32'd0);
    clk_en = 1'b1;
    tick(1'b0, 8'h00);
    #2 rst = 1'b0;
    #1 check_outputs();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'($urandom));

    // Single byte 0xA5
    tick(1'b1, 8'hA5);
    for (int e = 1; e < 46; e++) tick(1'b0, 8'($urandom));

    // Busy ignore, completion-edge ignore, then back-to-back 0x00
    tick(1'b1, 8'h3C);
    for (int e = 1; e < 40; e++)
      tick(e == 13, (e == 13) ? 8'hFF : 8'($urandom));
    tick(1'b1, 8'h55);
    tick(1'b1, 8'h00);
    for (int e = 0; e < 45; e++) tick(1'b0, 8'($urandom));

    // Mid-frame reset, then release with trmt already high
    tick(1'b1, 8'h00);
    for (int e = 1; e <= 17; e++) tick(1'b0, 8'($urandom));
    #2 rst = 1'b1;
    started = 0;
    #1 check_outputs();
    tick(1'b1, 8'h81);
    tick(1'b0, 8'h81);
    if4.trmt = 1'b1;
    if4.tx_data = 8'h81;
    #2 rst = 1'b0;
    tick(1'b1, 8'h81);
    for (int e = 1; e < 45; e++) tick(1'b0, 8'($urandom));

    // Random requests with tx_data changing every cycle
    for (int i = 0; i < 700; i++)
      tick(($urandom_range(0, 7) == 0), 8'($urandom));
    for (int i = 0; i < 45; i++) tick(1'b0, 8'($urandom));

    // Default baud divider
    sel4    = 1'b0;
    bdiv    = 434;
    started = 0;
    tick(1'b1, 8'h55);
    for (int e = 1; e < 4346; e++)
      tick(($urandom_range(0, 63) == 0), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
